jump_resolve_unit: RTL and testbench
====================================

# jump_resolve_unit

Resolves J, JAL, JR and JALR targets in the EX stage of the pipelined core and issues a registered PC redirect to fetch. Generalises the jump-address select with XLEN/immediate parametrisation, full EX/MEM and MEM/WB forwarding for the `rs` operand, and a load-use stall. Adds a circular return-address stack (RAS) that records link addresses and scores JR predictions. Sits between the ID/EX register and the PC-select logic.

## Interface
- XLEN, 32, datapath/address width
- IMM_W, 26, J-type immediate width; must satisfy IMM_W+2 < XLEN
- REG_W, 5, register index width
- RAS_DEPTH, 4, RAS entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- j_jump  in  1  J/JAL in ID/EX
- jr_jump  in  1  JR/JALR in ID/EX
- link  in  1  instruction writes link register (JAL/JALR)
- flush  in  1  squash the ID/EX instruction this cycle
- rs_id_ex  in  REG_W  JR source register index
- id_ex_addr  in  XLEN  register-file value of rs
- imm  in  IMM_W  J-type immediate
- pc  in  XLEN  PC of the jump instruction
- ex_mem_dst / mem_wb_dst  in  REG_W  destination indices
- ex_mem_wr / mem_wb_wr  in  1  destination write enables
- ex_mem_load  in  1  EX/MEM instruction is a load
- ex_mem_addr / mem_wb_addr  in  XLEN  forwarded result values
- stall_out  out  1  combinational load-use stall request
- redirect_valid  out  1  registered redirect strobe
- redirect_addr  out  XLEN  registered target
- ras_hit  out  1  registered: JR target equalled popped RAS entry
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries

## Operation
- Issue condition: (j_jump | jr_jump) & ~flush & ~stall_out.
- j_jump has priority when both jump inputs are high; jr_jump is then ignored.
- J target: {pc[XLEN-1:IMM_W+2], imm, 2'b00}.
- JR operand forwarding, in priority order:
  - EX/MEM when ex_mem_wr, ex_mem_dst == rs_id_ex, rs ≠ 0.
  - MEM/WB under the same rule.
  - Otherwise id_ex_addr. Register 0 never forwards.
- stall_out = jr_jump & ~j_jump & ~flush & ex_mem_load & ex_mem_wr & ex_mem_dst == rs_id_ex & rs_id_ex ≠ 0.
  - Upstream holds ID/EX; the next cycle the value arrives via MEM/WB.
- RAS: circular buffer with a top pointer. Updated only on issue.
  - Pop on JR issue when ras_count > 0.
  - ras_hit = popped entry equals the resolved target; 0 when empty.
  - Push pc+4 on a link issue (either jump type).
  - JALR pops then pushes: the top is replaced and the count is unchanged.
  - Push when full overwrites the oldest entry; the pointer wraps and ras_count saturates at RAS_DEPTH.
  - Pop when empty leaves all RAS state unchanged.
- flush suppresses redirect and RAS update, and cancels stall_out.

## Timing
- Reset values: redirect_valid=0, redirect_addr=0, ras_hit=0, ras_count=0, top pointer=0, all RAS entries 0.
- Latency: issue in cycle N → redirect_valid/redirect_addr/ras_hit valid in cycle N+1 for exactly one cycle.
- Without an issue, redirect_valid=0 and redirect_addr holds its last value.
- stall_out is combinational, in the same cycle as its inputs. A stalled JR issues no earlier than the following cycle.
- Reset asserted mid-operation clears all state immediately; any pending redirect is lost.

## Structure
- Shared package/header holds the parameter defaults and the jump-kind encoding (NONE, J, JR) used by the decoder.
- One sub-module, `ras_stack`: push/pop/replace ports, count and top outputs, with a DEPTH parameter.
- Forwarding mux, target formation and output registers sit in the top module.

## Test plan
- J with pc=0x4000_0010, imm=0x0000100 → N+1: redirect_valid=1, redirect_addr=0x4000_0400, RAS unchanged.
- JR with rs=8 when both EX/MEM and MEM/WB write r8 (0x100, 0x200) → redirect_addr=0x100. Repeat with rs=0 → id_ex_addr used.
- JR r9 with EX/MEM load to r9 → stall_out=1 and no redirect. Next cycle, MEM/WB r9=0x3C and no stall → redirect 0x3C.
- JAL at pc=0x10, then JR r31=0x14 → ras_hit=1 and ras_count returns 1→0. A second JR on the empty stack → ras_hit=0 and count stays 0.
- Five JALs (pc 0x0,0x10,0x20,0x30,0x40) with RAS_DEPTH=4 → count=4. Four pops return 0x44,0x34,0x24,0x14.
- JAL with flush=1 → no redirect, count unchanged. Assert rst during a redirect cycle → all outputs 0 immediately.

Source files
------------

// File: rtl/jump_resolve_unit_pkg.sv
// Shared defaults and jump-kind encoding for the EX-stage jump resolver.
package jump_resolve_unit_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int IMM_W_DEF     = 26;
    localparam int REG_W_DEF     = 5;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        JK_NONE = 2'd0,
        JK_J    = 2'd1,
        JK_JR   = 2'd2
    } jump_kind_e;

    // J/JAL wins over JR/JALR when the decoder raises both.
    function automatic jump_kind_e decode_kind(input logic j_jump, input logic jr_jump);
        jump_kind_e kind;
        if (j_jump) begin
            kind = JK_J;
        end else if (jr_jump) begin
            kind = JK_JR;
        end else begin
            kind = JK_NONE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/jump_resolve_unit_ras_stack.sv
// Circular return-address stack: push, pop, or replace-top (pop+push) per cycle.
module ras_stack
    import jump_resolve_unit_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int W     = XLEN_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [CW-1:0] count,
    output logic [W-1:0]  top_data
);

    logic [W-1:0]  entries_r [DEPTH];
    logic [PW-1:0] ptr_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] top_idx_s;
    logic          pop_ok_s;

    // ptr_r names the next free slot; the live top sits one below it.
    always_comb begin
        top_idx_s = ptr_r - PW'(1);
        pop_ok_s  = pop & (count_r != CW'(0));
    end

    // Stack state update; an empty pop leaves everything untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= {W{1'b0}};
            end
            ptr_r   <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (push && pop_ok_s) begin
            entries_r[top_idx_s] <= push_data;
        end else if (push) begin
            // When full this overwrites the oldest entry, which is the slot at ptr_r.
            entries_r[ptr_r] <= push_data;
            ptr_r            <= ptr_r + PW'(1);
            if (count_r != CW'(DEPTH)) begin
                count_r <= count_r + CW'(1);
            end else begin
                count_r <= count_r;
            end
        end else if (pop_ok_s) begin
            ptr_r   <= top_idx_s;
            count_r <= count_r - CW'(1);
        end else begin
            ptr_r   <= ptr_r;
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign top_data = entries_r[top_idx_s];

endmodule

// File: rtl/jump_resolve_unit.sv
// EX-stage J/JR target resolution with rs forwarding, load-use stall,
// registered fetch redirect and return-address-stack prediction scoring.
module jump_resolve_unit
    import jump_resolve_unit_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int IMM_W     = IMM_W_DEF,
    parameter int REG_W     = REG_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    localparam int CW       = $clog2(RAS_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             j_jump,
    input  logic             jr_jump,
    input  logic             link,
    input  logic             flush,
    input  logic [REG_W-1:0] rs_id_ex,
    input  logic [XLEN-1:0]  id_ex_addr,
    input  logic [IMM_W-1:0] imm,
    input  logic [XLEN-1:0]  pc,
    input  logic [REG_W-1:0] ex_mem_dst,
    input  logic [REG_W-1:0] mem_wb_dst,
    input  logic             ex_mem_wr,
    input  logic             mem_wb_wr,
    input  logic             ex_mem_load,
    input  logic [XLEN-1:0]  ex_mem_addr,
    input  logic [XLEN-1:0]  mem_wb_addr,
    output logic             stall_out,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_addr,
    output logic             ras_hit,
    output logic [CW-1:0]    ras_count
);

    jump_kind_e      kind_s;
    logic            fwd_ex_s;
    logic            fwd_wb_s;
    logic            stall_s;
    logic            issue_s;
    logic            ras_push_s;
    logic            ras_pop_s;
    logic            hit_s;
    logic [XLEN-1:0] jr_op_s;
    logic [XLEN-1:0] tgt_s;
    logic [XLEN-1:0] link_addr_s;
    logic [XLEN-1:0] ras_top_s;
    logic [CW-1:0]   ras_count_s;

    // Operand forwarding, stall detection, target formation and RAS controls.
    always_comb begin
        kind_s   = decode_kind(j_jump, jr_jump);
        fwd_ex_s = ex_mem_wr & (ex_mem_dst == rs_id_ex) & (rs_id_ex != REG_W'(0));
        fwd_wb_s = mem_wb_wr & (mem_wb_dst == rs_id_ex) & (rs_id_ex != REG_W'(0));
        // A load result is not ready in EX/MEM; hold one cycle and pick it up from MEM/WB.
        stall_s  = (kind_s == JK_JR) & ~flush & ex_mem_load & fwd_ex_s;

        if (fwd_ex_s) begin
            jr_op_s = ex_mem_addr;
        end else if (fwd_wb_s) begin
            jr_op_s = mem_wb_addr;
        end else begin
            jr_op_s = id_ex_addr;
        end

        case (kind_s)
            JK_J:    tgt_s = {pc[XLEN-1:IMM_W+2], imm, 2'b00};
            JK_JR:   tgt_s = jr_op_s;
            default: tgt_s = {XLEN{1'b0}};
        endcase

        issue_s     = (kind_s != JK_NONE) & ~flush & ~stall_s;
        ras_pop_s   = issue_s & (kind_s == JK_JR);
        ras_push_s  = issue_s & link;
        link_addr_s = pc + XLEN'(4);
        hit_s       = ras_pop_s & (ras_count_s != CW'(0)) & (ras_top_s == tgt_s);
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (link_addr_s),
        .count     (ras_count_s),
        .top_data  (ras_top_s)
    );

    // Redirect strobe and prediction score, one cycle after issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_addr  <= {XLEN{1'b0}};
            ras_hit        <= 1'b0;
        end else begin
            redirect_valid <= issue_s;
            ras_hit        <= hit_s;
            if (issue_s) begin
                redirect_addr <= tgt_s;
            end else begin
                redirect_addr <= redirect_addr;
            end
        end
    end

    assign stall_out = stall_s;
    assign ras_count = ras_count_s;

endmodule

// File: tb/tb_jump_resolve_unit.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_jump_resolve_unit;

    localparam int XLEN      = 32;
    localparam int IMM_W     = 26;
    localparam int REG_W     = 5;
    localparam int RAS_DEPTH = 4;
    localparam int CW        = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             j_jump, jr_jump, link, flush;
    logic [REG_W-1:0] rs_id_ex, ex_mem_dst, mem_wb_dst;
    logic [XLEN-1:0]  id_ex_addr, pc, ex_mem_addr, mem_wb_addr;
    logic [IMM_W-1:0] imm;
    logic             ex_mem_wr, mem_wb_wr, ex_mem_load;
    logic             stall_out, redirect_valid, ras_hit;
    logic [XLEN-1:0]  redirect_addr;
    logic [CW-1:0]    ras_count;

    jump_resolve_unit #(
        .XLEN(XLEN), .IMM_W(IMM_W), .REG_W(REG_W), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .j_jump(j_jump), .jr_jump(jr_jump), .link(link),
        .flush(flush), .rs_id_ex(rs_id_ex), .id_ex_addr(id_ex_addr), .imm(imm),
        .pc(pc), .ex_mem_dst(ex_mem_dst), .mem_wb_dst(mem_wb_dst),
        .ex_mem_wr(ex_mem_wr), .mem_wb_wr(mem_wb_wr), .ex_mem_load(ex_mem_load),
        .ex_mem_addr(ex_mem_addr), .mem_wb_addr(mem_wb_addr), .stall_out(stall_out),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .ras_hit(ras_hit), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        j, jr, link, flush;
        logic [4:0]  rs;
        logic [31:0] id_addr;
        logic [25:0] imm;
        logic [31:0] pc;
        logic [4:0]  exm_dst;
        logic        exm_wr, exm_load;
        logic [31:0] exm_addr;
        logic [4:0]  mwb_dst;
        logic        mwb_wr;
        logic [31:0] mwb_addr;
        logic        e_stall, e_valid;
        logic [31:0] e_addr;
        logic        e_hit;
        logic [2:0]  e_count;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: return stack as a queue (back = top), last redirect target.
    logic [31:0] m_q[$];
    logic [31:0] m_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic j, jr, lnk, fl, input logic [4:0] rs, input logic [31:0] ida,
                       input logic [25:0] im, input logic [31:0] p,
                       input logic [4:0] ed, input logic ew, el, input logic [31:0] ea,
                       input logic [4:0] md, input logic mw, input logic [31:0] ma,
                       input logic es, ev, input logic [31:0] eaddr, input logic eh,
                       input logic [2:0] ec);
        vec_t v;
        v.j = j; v.jr = jr; v.link = lnk; v.flush = fl; v.rs = rs; v.id_addr = ida;
        v.imm = im; v.pc = p; v.exm_dst = ed; v.exm_wr = ew; v.exm_load = el;
        v.exm_addr = ea; v.mwb_dst = md; v.mwb_wr = mw; v.mwb_addr = ma;
        v.e_stall = es; v.e_valid = ev; v.e_addr = eaddr; v.e_hit = eh; v.e_count = ec;
        tbl.push_back(v);
    endtask

    task automatic drive_idle();
        j_jump = 1'b0; jr_jump = 1'b0; link = 1'b0; flush = 1'b0;
        rs_id_ex = 5'd0; id_ex_addr = 32'd0; imm = 26'd0; pc = 32'd0;
        ex_mem_dst = 5'd0; ex_mem_wr = 1'b0; ex_mem_load = 1'b0; ex_mem_addr = 32'd0;
        mem_wb_dst = 5'd0; mem_wb_wr = 1'b0; mem_wb_addr = 32'd0;
    endtask

    // Reference behaviour for the inputs currently driven; updates model state.
    task automatic model_eval(output logic e_stall, output logic e_valid,
                              output logic [31:0] e_addr, output logic e_hit);
        logic        is_jr, issue;
        logic [31:0] op, tgt;
        is_jr   = jr_jump && !j_jump;
        e_stall = is_jr && !flush && ex_mem_load && ex_mem_wr &&
                  ex_mem_dst == rs_id_ex && rs_id_ex != 5'd0;
        issue   = (j_jump || jr_jump) && !flush && !e_stall;
        if (ex_mem_wr && ex_mem_dst == rs_id_ex && rs_id_ex != 5'd0) op = ex_mem_addr;
        else if (mem_wb_wr && mem_wb_dst == rs_id_ex && rs_id_ex != 5'd0) op = mem_wb_addr;
        else op = id_ex_addr;
        tgt = j_jump ? ((pc & 32'hF000_0000) | (32'(imm) << 2)) : op;
        e_hit = 1'b0;
        if (issue) begin
            m_addr = tgt;
            if (is_jr && m_q.size() > 0) begin
                e_hit = (m_q[$] == tgt);
                void'(m_q.pop_back());
            end
            if (link) begin
                m_q.push_back(pc + 32'd4);
                if (m_q.size() > RAS_DEPTH) void'(m_q.pop_front());
            end
        end
        e_valid = issue;
        e_addr  = m_addr;
    endtask

    initial begin
        logic        es, ev, eh;
        logic [31:0] ea;

        drive_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_valid", 32'(redirect_valid), 32'd0);
        check("reset_addr", redirect_addr, 32'd0);
        check("reset_hit", 32'(ras_hit), 32'd0);
        check("reset_count", 32'(ras_count), 32'd0);
        @(posedge clk); #1;

        //   j     jr    lnk   fl    rs     id_addr        imm        pc             exm_dst wr   ld    exm_addr     mwb_dst wr  mwb_addr     stall valid addr          hit   cnt
        add(1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'd0,         26'h100,   32'h4000_0010, 5'd0,  1'b0, 1'b0, 32'd0,       5'd0,  1'b0, 32'd0,       1'b0, 1'b1, 32'h4000_0400, 1'b0, 3'd0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 5'd8,  32'hDEAD_0000, 26'd0,     32'd0,         5'd8,  1'b1, 1'b0, 32'h100,     5'd8,  1'b1, 32'h200,     1'b0, 1'b1, 32'h100,       1'b0, 3'd0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0ABC, 26'd0,     32'd0,         5'd0,  1'b1, 1'b0, 32'h100,     5'd0,  1'b1, 32'h200,     1'b0, 1'b1, 32'h0ABC,      1'b0, 3'd0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 5'd9,  32'd0,         26'd0,     32'd0,         5'd9,  1'b1, 1'b1, 32'h77,      5'd0,  1'b0, 32'd0,       1'b1, 1'b0, 32'h0ABC,      1'b0, 3'd0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 5'd9,  32'd0,         26'd0,     32'd0,         5'd0,  1'b0, 1'b0, 32'd0,       5'd9,  1'b1, 32'h3C,      1'b0, 1'b1, 32'h3C,        1'b0, 3'd0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  32'd0,         26'h40,    32'h10,        5'd0,  1'b0, 1'b0, 32'd0,       5'd0,  1'b0, 32'd0,       1'b0, 1'b1, 32'h100,       1'b0, 3'd1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 5'd31, 32'h14,        26'd0,     32'd0,         5'd0,  1'b0, 1'b0, 32'd0,       5'd0,  1'b0, 32'd0,       1'b0, 1'b1, 32'h14,        1'b1, 3'd0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 5'd31, 32'h14,        26'd0,     32'd0,         5'd0,  1'b0, 1'b0, 32'd0,       5'd0,  1'b0, 32'd0,       1'b0, 1'b1, 32'h14,        1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            add(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 26'd0, 32'(i * 16), 5'd0, 1'b0, 1'b0, 32'd0,
                5'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, (i < 4) ? 3'(i + 1) : 3'd4);
        end
        for (int i = 0; i < 4; i++) begin
            add(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'(32'h44 - i * 16), 26'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0,
                5'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'(32'h44 - i * 16), 1'b1, 3'(3 - i));
        end
        add(1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  32'd0,         26'd0,     32'h100,       5'd0,  1'b0, 1'b0, 32'd0,       5'd0,  1'b0, 32'd0,       1'b0, 1'b0, 32'h14,        1'b0, 3'd0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 5'd9,  32'd0,         26'd0,     32'd0,         5'd9,  1'b1, 1'b1, 32'h77,      5'd0,  1'b0, 32'd0,       1'b0, 1'b0, 32'h14,        1'b0, 3'd0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 5'd9,  32'd0,         26'd3,     32'h8000_0000, 5'd9,  1'b1, 1'b1, 32'h77,      5'd0,  1'b0, 32'd0,       1'b0, 1'b1, 32'h8000_000C, 1'b0, 3'd0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'd0,         26'd0,     32'd0,         5'd0,  1'b0, 1'b0, 32'd0,       5'd0,  1'b0, 32'd0,       1'b0, 1'b0, 32'h8000_000C, 1'b0, 3'd0);

        foreach (tbl[k]) begin
            j_jump = tbl[k].j; jr_jump = tbl[k].jr; link = tbl[k].link; flush = tbl[k].flush;
            rs_id_ex = tbl[k].rs; id_ex_addr = tbl[k].id_addr; imm = tbl[k].imm; pc = tbl[k].pc;
            ex_mem_dst = tbl[k].exm_dst; ex_mem_wr = tbl[k].exm_wr; ex_mem_load = tbl[k].exm_load;
            ex_mem_addr = tbl[k].exm_addr; mem_wb_dst = tbl[k].mwb_dst; mem_wb_wr = tbl[k].mwb_wr;
            mem_wb_addr = tbl[k].mwb_addr;
            #1;
            check($sformatf("vec%0d_stall", k), 32'(stall_out), 32'(tbl[k].e_stall));
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", k), 32'(redirect_valid), 32'(tbl[k].e_valid));
            check($sformatf("vec%0d_addr", k), redirect_addr, tbl[k].e_addr);
            check($sformatf("vec%0d_hit", k), 32'(ras_hit), 32'(tbl[k].e_hit));
            check($sformatf("vec%0d_count", k), 32'(ras_count), 32'(tbl[k].e_count));
        end

        // Reset asserted while a redirect is being presented.
        drive_idle();
        j_jump = 1'b1; link = 1'b1; pc = 32'h200; imm = 26'h80;
        @(posedge clk); #1;
        check("pre_rst_valid", 32'(redirect_valid), 32'd1);
        check("pre_rst_count", 32'(ras_count), 32'd1);
        drive_idle();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(redirect_valid), 32'd0);
        check("mid_rst_addr", redirect_addr, 32'd0);
        check("mid_rst_hit", 32'(ras_hit), 32'd0);
        check("mid_rst_count", 32'(ras_count), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        m_q.delete();
        m_addr = 32'd0;

        for (int c = 0; c < 600; c++) begin
            j_jump      = ($urandom % 4) == 0;
            jr_jump     = ($urandom % 3) == 0;
            link        = $urandom % 2;
            flush       = ($urandom % 8) == 0;
            rs_id_ex    = 5'($urandom % 4);
            ex_mem_dst  = 5'($urandom % 4);
            mem_wb_dst  = 5'($urandom % 4);
            ex_mem_wr   = $urandom % 2;
            mem_wb_wr   = $urandom % 2;
            ex_mem_load = ($urandom % 3) == 0;
            ex_mem_addr = $urandom;
            mem_wb_addr = $urandom;
            pc          = $urandom & 32'hFFFF_FFFC;
            imm         = 26'($urandom);
            id_ex_addr  = (m_q.size() > 0 && ($urandom % 2) == 0) ? m_q[$] : $urandom;
            #1;
            model_eval(es, ev, ea, eh);
            check("rnd_stall", 32'(stall_out), 32'(es));
            @(posedge clk); #1;
            check("rnd_valid", 32'(redirect_valid), 32'(ev));
            check("rnd_addr", redirect_addr, ea);
            check("rnd_hit", 32'(ras_hit), 32'(eh));
            check("rnd_count", 32'(ras_count), 32'(m_q.size()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
